// File: rtl/riscv_pkg.sv
// Defaults and the buffer entry layout shared by the fetch front end.
package riscv_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a flush that empties it in one cycle.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN_DEF + ILEN_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == (AW+1)'(DEPTH));
  assign count_o   = r_count;
  assign rd_data_o = r_mem[r_rd_ptr];

  // A write into a full FIFO is only legal when the head leaves the same cycle.
  assign w_do_rd = rd_en_i && !empty_o;
  assign w_do_wr = wr_en_i && (!full_o || w_do_rd) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response
// capture into a small buffer, and redirect flush with stale-response dropping.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              ILEN            = ILEN_DEF,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     imem_req_valid_o,
  input  logic                     imem_req_ready_i,
  output logic [XLEN-1:0]          imem_req_addr_o,
  input  logic                     imem_rsp_valid_i,
  input  logic [ILEN-1:0]          imem_rsp_instr_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     D_valid_o,
  input  logic                     D_ready_i,
  output logic [XLEN-1:0]          D_pc_o,
  output logic [ILEN-1:0]          D_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + ILEN;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;
  logic [CW-1:0]   w_outstanding_nxt;
  logic [CW-1:0]   w_count;
  logic            w_req_valid;
  logic            w_req_hs;
  logic            w_rsp_ok;
  logic            w_wr_en;
  logic            w_rd_en;
  logic            w_empty;
  logic            w_full;
  logic [EW-1:0]   w_wr_data;
  logic [EW-1:0]   w_rd_data;

  // Every in-flight request already owns a buffer slot, so the buffer can never overflow.
  assign w_req_valid = (({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_C)
                       && (r_outstanding < MAXO_C);
  assign w_req_hs    = w_req_valid && imem_req_ready_i;
  assign w_rsp_ok    = imem_rsp_valid_i && (r_outstanding != '0);

  assign w_outstanding_nxt = r_outstanding + CW'(w_req_hs) - CW'(w_rsp_ok);

  assign w_wr_en   = w_rsp_ok && (r_drop_cnt == '0) && !redirect_i;
  assign w_rd_en   = !w_empty && D_ready_i;
  assign w_wr_data = {r_rsp_pc, imem_rsp_instr_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_i) begin
        r_fetch_pc <= redirect_pc_i;
        r_rsp_pc   <= redirect_pc_i;
        r_drop_cnt <= w_outstanding_nxt;
      end else begin
        if (w_req_hs) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_rsp_ok) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
          else                  r_rsp_pc   <= r_rsp_pc + XLEN'(4);
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (redirect_i),
    .wr_en_i   (w_wr_en),
    .wr_data_i (w_wr_data),
    .rd_en_i   (w_rd_en),
    .rd_data_o (w_rd_data),
    .empty_o   (w_empty),
    .full_o    (w_full),
    .count_o   (w_count)
  );

  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_fetch_pc;
  assign D_valid_o        = !w_empty;
  assign count_o          = w_count;
  // Head fields read as zero while empty so reset and flush present a clean bus.
  assign D_pc_o           = w_empty ? '0 : w_rd_data[EW-1:ILEN];
  assign D_instr_o        = w_empty ? '0 : w_rd_data[ILEN-1:0];

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int          XLEN  = 64;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [63:0] RPC   = 64'h0;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             imem_req_valid_o;
  logic             imem_req_ready_i = 1'b0;
  logic [XLEN-1:0]  imem_req_addr_o;
  logic             imem_rsp_valid_i = 1'b0;
  logic [ILEN-1:0]  imem_rsp_instr_i = '0;
  logic             redirect_i = 1'b0;
  logic [XLEN-1:0]  redirect_pc_i = '0;
  logic             D_valid_o;
  logic             D_ready_i = 1'b0;
  logic [XLEN-1:0]  D_pc_o;
  logic [ILEN-1:0]  D_instr_o;
  logic [2:0]       count_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_instr_i(imem_rsp_instr_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .D_valid_o(D_valid_o), .D_ready_i(D_ready_i),
    .D_pc_o(D_pc_o), .D_instr_o(D_instr_o), .count_o(count_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: decode-side buffer as a queue, memory in-flight addresses as a queue.
  fetch_entry_t m_q[$];
  logic [63:0]  mem_pend[$];
  logic [63:0]  m_fetch_pc;
  logic [63:0]  m_rsp_pc;
  int           m_outs;
  int           m_drop;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'd3) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  function automatic logic exp_req_valid();
    return ((m_q.size() + m_outs) < DEPTH) && (m_outs < MAXO);
  endfunction

  task automatic model_reset();
    m_q.delete();
    mem_pend.delete();
    m_fetch_pc = RPC;
    m_rsp_pc   = RPC;
    m_outs     = 0;
    m_drop     = 0;
  endtask

  task automatic drive_idle();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_instr_i = '0;
    redirect_i       = 1'b0;
    D_ready_i        = 1'b0;
  endtask

  task automatic check_outputs();
    logic rv;
    rv = exp_req_valid();
    check_val("req_valid", imem_req_valid_o, rv);
    if (rv) check_val("req_addr", imem_req_addr_o, m_fetch_pc);
    check_val("d_valid", D_valid_o, m_q.size() != 0);
    check_val("count", count_o, m_q.size());
    if (m_q.size() != 0) begin
      check_val("d_pc", D_pc_o, m_q[0].pc);
      check_val("d_instr", D_instr_o, m_q[0].instr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_idle();
    #1;
    check_val("rst_count", count_o, 0);
    check_val("rst_d_valid", D_valid_o, 0);
    check_val("rst_req_valid", imem_req_valid_o, 1);
    check_val("rst_req_addr", imem_req_addr_o, RPC);
    check_val("rst_d_pc", D_pc_o, 0);
    check_val("rst_d_instr", D_instr_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic do_cycle(input int pr_ready, input int pr_rsp, input int pr_dready,
                          input int pr_redir, input bit force_redir, input logic [63:0] force_pc);
    logic         hs, rsp_ok, pop, rv_exp, rv;
    logic [31:0]  rin;
    int           outs_n;
    fetch_entry_t e;
    @(negedge clk_i);
    check_outputs();
    rv_exp = exp_req_valid();
    imem_req_ready_i = (int'($urandom_range(0, 99)) < pr_ready);
    D_ready_i        = (int'($urandom_range(0, 99)) < pr_dready);
    rv  = 1'b0;
    rin = '0;
    if (mem_pend.size() != 0) begin
      if (int'($urandom_range(0, 99)) < pr_rsp) begin
        rv  = 1'b1;
        rin = instr_of(mem_pend.pop_front());
      end
    end else if ($urandom_range(0, 99) < 3) begin
      rv  = 1'b1;
      rin = $urandom;
    end
    imem_rsp_valid_i = rv;
    imem_rsp_instr_i = rin;
    redirect_i = force_redir || (int'($urandom_range(0, 99)) < pr_redir);
    if (force_redir)                   redirect_pc_i = force_pc;
    else if ($urandom_range(0, 3) == 0) redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF4;
    else                               redirect_pc_i = {32'h0, $urandom} & ~64'h3;

    hs     = rv_exp && imem_req_ready_i;
    rsp_ok = rv && (m_outs > 0);
    pop    = (m_q.size() != 0) && D_ready_i;
    if (hs) mem_pend.push_back(m_fetch_pc);
    outs_n = m_outs + int'(hs) - int'(rsp_ok);
    m_outs = outs_n;
    if (redirect_i) begin
      m_q.delete();
      m_fetch_pc = redirect_pc_i;
      m_rsp_pc   = redirect_pc_i;
      m_drop     = outs_n;
    end else begin
      if (hs)  m_fetch_pc = m_fetch_pc + 64'd4;
      if (pop) void'(m_q.pop_front());
      if (rsp_ok) begin
        if (m_drop > 0) m_drop--;
        else begin
          e.pc    = m_rsp_pc;
          e.instr = rin;
          m_q.push_back(e);
          m_rsp_pc = m_rsp_pc + 64'd4;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    drive_idle();
    do_reset();

    // Streaming with a one-cycle memory and an always-ready decoder.
    for (int i = 0; i < 30; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Decoder stall fills the buffer; requests must stop.
    for (int i = 0; i < 12; i++) do_cycle(100, 100, 0, 0, 1'b0, '0);
    @(negedge clk_i);
    check_val("stall_count", count_o, DEPTH);
    check_val("stall_req_valid", imem_req_valid_o, 0);
    for (int i = 0; i < 10; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Build two outstanding requests, then redirect.
    for (int i = 0; i < 4; i++) do_cycle(100, 0, 100, 0, 1'b0, '0);
    do_cycle(100, 0, 100, 0, 1'b1, 64'h100);
    for (int i = 0; i < 12; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Redirect coinciding with handshake and response.
    do_cycle(100, 100, 100, 0, 1'b1, 64'h200);
    for (int i = 0; i < 12; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Fetch address wrap at the top of the address space.
    do_cycle(100, 100, 100, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 12; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Reset with a full buffer and requests still in flight.
    for (int i = 0; i < 10; i++) do_cycle(100, 60, 0, 0, 1'b0, '0);
    do_reset();
    for (int i = 0; i < 10; i++) do_cycle(100, 100, 100, 0, 1'b0, '0);

    // Long randomized mix.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else do_cycle(int'($urandom_range(30, 100)), int'($urandom_range(20, 90)),
                    int'($urandom_range(10, 100)), 5, 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
